ahb3lite_interconnect_switch_ctrl: RTL and testbench
====================================================

# ahb3lite_interconnect_switch_ctrl

Per-master-port switch controller for the AHB3-Lite multi-layer interconnect. It tracks the burst and lock state of one AHB master and drives that master's `can_switch` bit into every slave port. Slave-port arbiters therefore re-arbitrate only at legal boundaries: end of a fixed-length burst, end of a locked sequence, or a single/idle transfer. It also flags burst-protocol violations. One instance is placed per master port.

## Interface

**Parameters**

- `MAX_INCR_BEATS`, default 16: beat limit for undefined-length INCR bursts before a forced switch point. Legal range is 2..1024. Used only with `AHB3LITE_SWITCH_INCR_TIMEOUT_EN`.

**Ports**

- `HCLK` in 1: clock, rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `HSEL` in 1: master port selects any slave.
- `HTRANS` in 2: encodings are IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `HBURST` in 3: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- `HMASTLOCK` in 1: locked-sequence indicator.
- `HREADY` in 1: bus HREADY seen by the master.
- `can_switch` out 1: the slave port may change master after the current address phase.
- `burst_active` out 1: registered; high while a multi-beat burst is in progress.
- `seq_err` out 1: registered one-cycle pulse on a burst protocol violation.

## Operation

**Accepted beat:** `HREADY & HSEL & HTRANS[1]`. Only accepted beats change state.

**FSM states**

- IDLE
- FIXED: WRAP/INCR 4/8/16 in progress
- UNDEF: INCR in progress
- LOCKED: HMASTLOCK sequence in progress; burst tracking continues inside it

**Remaining-beat counter `beats_left` (5 bits)**

- A NONSEQ with burst length L>1 loads L-1 and enters FIXED.
- Each accepted SEQ in FIXED decrements it.
- A SEQ that makes it 0 returns the FSM to IDLE, or to LOCKED if HMASTLOCK=1.

**INCR**

- A NONSEQ with HBURST=INCR enters UNDEF.
- The burst terminates on the next accepted NONSEQ, or on any cycle with `HREADY & (!HSEL | HTRANS==IDLE)`.

**SINGLE:** leaves the FSM in IDLE (or LOCKED if HMASTLOCK=1).

**`can_switch` (combinational from current inputs and registered state)** is 0 if any of these holds, otherwise 1:

- HMASTLOCK=1.
- HTRANS=BUSY.
- HTRANS=NONSEQ with burst length >1, except INCR, which follows the timeout rule.
- HTRANS=SEQ in FIXED with `beats_left>1`.
- HTRANS=SEQ in UNDEF with no timeout reached.

It is 1 for the last SEQ of a fixed burst, SINGLE, IDLE, or HSEL=0 (lock not asserted).

**`seq_err` pulses** (next cycle, with HREADY=1) when:

- SEQ or BUSY is accepted while in IDLE or LOCKED with no burst; or
- NONSEQ arrives in FIXED with `beats_left!=0` (early termination).

**On an error:**

- The FSM re-evaluates the NONSEQ as a new burst.
- A stray SEQ is treated as SINGLE.

**Locked sequences:** LOCKED exits on the first HREADY-qualified cycle with HMASTLOCK=0, provided no burst is open.

## Timing

- `can_switch` has zero latency: it is valid in the same cycle as the address phase it describes, and the slave port samples it when its HREADY=1.
- `beats_left`, FSM, `burst_active` and `seq_err` update on the rising HCLK edge of a qualifying cycle.
- With HREADY=0, all state holds and `can_switch` continues to reflect current inputs.
- **Reset values:** FSM=IDLE, `beats_left`=0, incr counter=0, `burst_active`=0, `seq_err`=0. `can_switch`=1 while inputs are idle.
- **Reset mid-burst:** everything returns immediately to the reset values; the next SEQ raises `seq_err`.
- **Simultaneous last SEQ and HMASTLOCK=1:** `can_switch`=0 and the FSM goes to LOCKED.

## Configuration

Macro: `AHB3LITE_SWITCH_INCR_TIMEOUT_EN`.

- **Defined:**
  - A counter of width `$clog2(MAX_INCR_BEATS+1)` counts accepted beats in UNDEF, with the NONSEQ as beat 1.
  - When the beat presented is beat `MAX_INCR_BEATS`, `can_switch`=1 (unless HMASTLOCK=1) and the counter reloads to 0.
  - The following SEQ counts as beat 1.
  - The FSM stays in UNDEF; SEQ-to-NONSEQ conversion is the slave port's job.
- **Undefined:**
  - The counter is absent.
  - INCR holds the slave until the master terminates the burst.
  - `MAX_INCR_BEATS` is ignored.

## Test plan

1. **INCR4:** NONSEQ followed by 3 SEQ, HREADY=1 → `can_switch` = 0,0,0,1; `burst_active` high for 3 cycles; `seq_err`=0.
2. **WRAP8 with BUSY and wait states:** BUSY inserted after beat 3, HREADY=0 for 2 cycles on beat 5 → `can_switch`=0 on BUSY and on beats 1-7, 1 only on beat 8; `beats_left` holds during HREADY=0.
3. **Locked sequence:** HMASTLOCK=1 across SINGLE, SINGLE, then IDLE with HMASTLOCK=0 → `can_switch` = 0,0,1; FSM LOCKED→IDLE.
4. **INCR timeout** (macro defined, `MAX_INCR_BEATS`=4, 10-beat INCR) → `can_switch`=1 only on beats 4 and 8; without the macro, always 0 until the closing IDLE.
5. **Early termination:** NONSEQ INCR8 after 2 beats → `seq_err` pulses once; `beats_left` reloads to 7.
6. **Reset mid-burst:** HRESETn low during beat 2 of INCR16 → all outputs at reset values; the next SEQ gives `seq_err`=1.

Source files
------------

// File: rtl/ahb3lite_interconnect_switch_ctrl.sv
// Per-master AHB3-Lite burst/lock tracker that tells slave ports when re-arbitration is legal.
// Optional INCR beat timeout: define AHB3LITE_SWITCH_INCR_TIMEOUT_EN.
module ahb3lite_interconnect_switch_ctrl #(
    parameter int MAX_INCR_BEATS = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    input  logic       HMASTLOCK,
    input  logic       HREADY,
    output logic       can_switch,
    output logic       burst_active,
    output logic       seq_err
);

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_INCR   = 3'd1;

    if (MAX_INCR_BEATS < 2 || MAX_INCR_BEATS > 1024) begin : g_param_chk
        $error("MAX_INCR_BEATS must be within 2..1024");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIXED,
        S_UNDEF,
        S_LOCKED
    } state_t;

    state_t     state_q, state_d;
    state_t     end_state;
    logic [4:0] beats_left_q, beats_left_d;
    logic       burst_active_q, burst_active_d;
    logic       seq_err_q, seq_err_d;

    logic       accepted;
    logic       is_idle, is_busy, is_nonseq, is_seq;
    logic       burst_open;
    logic       incr_timeout;
    logic [4:0] len_m1;

    assign is_idle    = (HTRANS == T_IDLE);
    assign is_busy    = (HTRANS == T_BUSY);
    assign is_nonseq  = (HTRANS == T_NONSEQ);
    assign is_seq     = (HTRANS == T_SEQ);
    assign accepted   = HREADY & HSEL & HTRANS[1];
    assign burst_open = (state_q == S_FIXED) || (state_q == S_UNDEF);
    assign end_state  = HMASTLOCK ? S_LOCKED : S_IDLE;

    // Remaining beats after the NONSEQ; zero for SINGLE and INCR.
    always_comb begin
        len_m1 = 5'd0;
        unique case (HBURST)
            3'd2, 3'd3: len_m1 = 5'd3;
            3'd4, 3'd5: len_m1 = 5'd7;
            3'd6, 3'd7: len_m1 = 5'd15;
            default:    len_m1 = 5'd0;
        endcase
    end

`ifdef AHB3LITE_SWITCH_INCR_TIMEOUT_EN
    localparam int CW = $clog2(MAX_INCR_BEATS + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_INCR_BEATS);

    logic [CW-1:0] incr_cnt_q, incr_cnt_d;

    assign incr_timeout = (state_q == S_UNDEF) && is_seq &&
                          ((incr_cnt_q + CW'(1)) == MAX_C);

    always_comb begin
        incr_cnt_d = incr_cnt_q;
        if (accepted && is_nonseq) begin
            incr_cnt_d = (HBURST == B_INCR) ? CW'(1) : '0;
        end else if (accepted && state_q == S_UNDEF) begin
            incr_cnt_d = incr_timeout ? '0 : incr_cnt_q + CW'(1);
        end else if (HREADY && state_q == S_UNDEF && (!HSEL || is_idle)) begin
            incr_cnt_d = '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            incr_cnt_q <= '0;
        end else begin
            incr_cnt_q <= incr_cnt_d;
        end
    end
`else
    assign incr_timeout = 1'b0;
`endif

    always_comb begin
        can_switch = 1'b1;
        if (HMASTLOCK) begin
            can_switch = 1'b0;
        end else if (HSEL) begin
            unique case (HTRANS)
                T_BUSY:   can_switch = 1'b0;
                T_NONSEQ: can_switch = (len_m1 == 5'd0) && (HBURST != B_INCR);
                T_SEQ: begin
                    unique case (state_q)
                        S_FIXED: can_switch = (beats_left_q == 5'd1);
                        S_UNDEF: can_switch = incr_timeout;
                        default: can_switch = 1'b1;
                    endcase
                end
                default:  can_switch = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        seq_err_d    = 1'b0;
        if (accepted && is_nonseq) begin
            // A NONSEQ always starts a fresh burst, even one cutting a fixed burst short.
            seq_err_d = (state_q == S_FIXED) && (beats_left_q != 5'd0);
            if (HBURST == B_INCR) begin
                state_d      = S_UNDEF;
                beats_left_d = 5'd0;
            end else if (len_m1 != 5'd0) begin
                state_d      = S_FIXED;
                beats_left_d = len_m1;
            end else begin
                state_d      = end_state;
                beats_left_d = 5'd0;
            end
        end else if (accepted) begin
            unique case (state_q)
                S_FIXED: begin
                    beats_left_d = beats_left_q - 5'd1;
                    if (beats_left_q == 5'd1) begin
                        state_d = end_state;
                    end
                end
                S_UNDEF: state_d = S_UNDEF;
                default: begin
                    seq_err_d = 1'b1;
                    state_d   = end_state;
                end
            endcase
        end else if (HREADY && state_q == S_UNDEF) begin
            if (!HSEL || is_idle) begin
                state_d = end_state;
            end
        end else if (HREADY && !burst_open) begin
            seq_err_d = HSEL & is_busy;
            state_d   = end_state;
        end
        burst_active_d = (state_d == S_FIXED) || (state_d == S_UNDEF);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= S_IDLE;
            beats_left_q   <= 5'd0;
            burst_active_q <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            beats_left_q   <= beats_left_d;
            burst_active_q <= burst_active_d;
            seq_err_q      <= seq_err_d;
        end
    end

    assign burst_active = burst_active_q;
    assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_ahb3lite_interconnect_switch_ctrl.sv
// Scoreboard bench for ahb3lite_interconnect_switch_ctrl against a beat-counting reference model.
// Honours AHB3LITE_SWITCH_INCR_TIMEOUT_EN the same way the design does.
module tb_ahb3lite_interconnect_switch_ctrl;

    localparam int MAXB = 4;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       HSEL = 1'b0;
    logic [1:0] HTRANS = 2'd0;
    logic [2:0] HBURST = 3'd0;
    logic       HMASTLOCK = 1'b0;
    logic       HREADY = 1'b1;
    logic       can_switch;
    logic       burst_active;
    logic       seq_err;

    typedef struct packed {
        logic cs;
        logic ba;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;

`ifdef AHB3LITE_SWITCH_INCR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Reference model: beats still owed by a fixed burst, whether an INCR
    // is open, how many INCR beats since the last switch point, and the
    // error pulse due after the coming edge.
    int m_rem = 0;
    bit m_incr = 0;
    int m_beats = 0;
    bit m_err = 0;

    ahb3lite_interconnect_switch_ctrl #(
        .MAX_INCR_BEATS(MAXB)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HBURST      (HBURST),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .can_switch  (can_switch),
        .burst_active(burst_active),
        .seq_err     (seq_err)
    );

    always #5 HCLK = ~HCLK;

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic bit m_cs(input logic sel, input logic [1:0] tr,
                                input logic [2:0] bu, input logic lk);
        if (lk) return 1'b0;
        if (!sel) return 1'b1;
        case (tr)
            2'd0: return 1'b1;
            2'd1: return 1'b0;
            2'd2: return burst_len(bu) == 1;
            default: begin
                if (m_rem > 0) return m_rem == 1;
                if (m_incr) return TO_EN && (m_beats + 1 == MAXB);
                return 1'b1;
            end
        endcase
    endfunction

    task automatic m_step(input logic sel, input logic [1:0] tr,
                          input logic [2:0] bu, input logic rdy);
        m_err = 1'b0;
        if (!rdy) return;
        if (sel && tr == 2'd2) begin
            m_err = (m_rem > 0);
            m_incr = (bu == 3'd1);
            m_beats = m_incr ? 1 : 0;
            m_rem = (burst_len(bu) > 1) ? burst_len(bu) - 1 : 0;
        end else if (sel && tr == 2'd3) begin
            if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end else if (m_incr) begin
                m_beats = (TO_EN && m_beats + 1 == MAXB) ? 0 : m_beats + 1;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_incr) begin
            if (!sel || tr == 2'd0) begin
                m_incr = 1'b0;
                m_beats = 0;
            end
        end else if (m_rem == 0) begin
            m_err = sel && tr == 2'd1;
        end
    endtask

    task automatic cyc(input logic rn, input logic sel, input logic [1:0] tr,
                       input logic [2:0] bu, input logic lk, input logic rdy);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESETn = rn;
        HSEL = sel;
        HTRANS = tr;
        HBURST = bu;
        HMASTLOCK = lk;
        HREADY = rdy;
        if (!rn) begin
            m_rem = 0;
            m_incr = 0;
            m_beats = 0;
            m_err = 0;
        end
        e.cs = m_cs(sel, tr, bu, lk);
        e.ba = (m_rem > 0) || m_incr;
        e.err = m_err;
        exp_q.push_back(e);
        if (rn) m_step(sel, tr, bu, rdy);
    endtask

    task automatic beat(input logic [1:0] tr, input logic [2:0] bu,
                        input logic lk);
        logic rdy;
        do begin
            rdy = ($urandom_range(0, 4) != 0);
            cyc(1'b1, 1'b1, tr, bu, lk, rdy);
        end while (!rdy);
    endtask

    task automatic rnd_burst();
        logic [2:0] bu;
        logic       lk;
        int         n;
        bu = 3'($urandom_range(0, 7));
        lk = ($urandom_range(0, 9) == 0);
        n = (bu == 3'd1) ? $urandom_range(1, 12) : burst_len(bu);
        beat(2'd2, bu, lk);
        for (int i = 1; i < n; i++) begin
            if ($urandom_range(0, 4) == 0) cyc(1'b1, 1'b1, 2'd1, bu, lk, 1'b1);
            beat(2'd3, bu, lk);
        end
        if ($urandom_range(0, 1) == 0) cyc(1'b1, 1'b1, 2'd0, bu, lk, 1'b1);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_n, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            cyc_n++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("can_switch", can_switch, e.cs);
                chk("burst_active", burst_active, e.ba);
                chk("seq_err", seq_err, e.err);
            end
        end
    end

    initial begin
        int wait_n;
        // Reset state
        repeat (3) cyc(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
        // INCR4
        cyc(1'b1, 1'b1, 2'd2, 3'd3, 1'b0, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 2'd3, 3'd3, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        // WRAP8 with BUSY after beat 3 and two wait states on beat 5
        cyc(1'b1, 1'b1, 2'd2, 3'd4, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd1, 3'd4, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b1);
        repeat (2) cyc(1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        // Locked SINGLE, SINGLE, then IDLE unlocked
        repeat (2) cyc(1'b1, 1'b1, 2'd2, 3'd0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        // 10-beat INCR
        cyc(1'b1, 1'b1, 2'd2, 3'd1, 1'b0, 1'b1);
        repeat (9) cyc(1'b1, 1'b1, 2'd3, 3'd1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        // Early termination of INCR8 after 2 beats
        cyc(1'b1, 1'b1, 2'd2, 3'd5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd3, 3'd5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd2, 3'd5, 1'b0, 1'b1);
        repeat (7) cyc(1'b1, 1'b1, 2'd3, 3'd5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        // Reset during beat 2 of INCR16, then a stray SEQ
        cyc(1'b1, 1'b1, 2'd2, 3'd7, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 2'd3, 3'd7, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd3, 3'd7, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1);
        // Randomized traffic with occasional arbitrary cycles
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                cyc(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) != 0));
            end else begin
                rnd_burst();
            end
        end
        repeat (2) cyc(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 10) begin
            @(posedge HCLK);
            wait_n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
